// File: rtl/jericalla_multiciclo.sv
// Multi-cycle register/RAM datapath: IDLE -> DECODE -> EXEC -> (MEM) -> WB.
// One instruction in flight; completion signalled by a one-cycle done pulse.
module jericalla_multiciclo #(
    parameter  int DATA_W     = 32,
    parameter  int REG_ADDR_W = 5,
    parameter  int RAM_ADDR_W = 5,
    localparam int IW         = 4 + 3*REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     instruction,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              zf,
    output logic              ovf,
    output logic              done,
    output logic              illegal
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

    localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2,
                           OP_SUB = 4'd3, OP_SLT = 4'd4, OP_NOR = 4'd5,
                           OP_SW  = 4'd6, OP_LW  = 4'd7, OP_LI  = 4'd8;
    localparam int M = DATA_W - 1;

    state_t                  state;
    logic                    armed;
    logic [IW-1:0]           ir;
    logic [DATA_W-1:0]       a, b, res;
    logic [DATA_W-1:0]       regs [2**REG_ADDR_W];
    logic [DATA_W-1:0]       ram  [2**RAM_ADDR_W];

    logic [3:0]              op;
    logic [REG_ADDR_W-1:0]   rd, rs, rt;
    logic [RAM_ADDR_W-1:0]   ram_addr;
    logic [DATA_W+2*REG_ADDR_W-1:0] li_ext;
    logic [DATA_W-1:0]       sum, diff, alu_res;
    logic                    alu_ovf, accept;

    assign op       = ir[IW-1 -: 4];
    assign rd       = ir[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rs       = ir[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rt       = ir[REG_ADDR_W-1:0];
    assign ram_addr = a[RAM_ADDR_W-1:0];
    assign li_ext   = {{DATA_W{1'b0}}, rs, rt};
    assign sum      = a + b;
    assign diff     = a - b;

    assign instr_ready = (state == IDLE);
    // armed delays the first accept to the second edge after reset release
    assign accept      = instr_ready && instr_valid && armed;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR: alu_res = ~(a | b);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            armed    <= 1'b0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            res      <= '0;
            data_out <= '0;
            zf       <= 1'b0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            armed   <= 1'b1;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    ir    <= instruction;
                    state <= DECODE;
                end
                DECODE: if (op > OP_LI) begin
                    done    <= 1'b1;
                    illegal <= 1'b1;
                    state   <= IDLE;
                end else begin
                    a     <= regs[rs];
                    b     <= regs[rt];
                    state <= EXEC;
                end
                EXEC: case (op)
                    OP_SW, OP_LW: state <= MEM;
                    OP_LI: begin
                        res   <= li_ext[DATA_W-1:0];
                        state <= WB;
                    end
                    default: begin
                        res   <= alu_res;
                        zf    <= (alu_res == '0);
                        ovf   <= alu_ovf;
                        state <= WB;
                    end
                endcase
                MEM: if (op == OP_SW) begin
                    data_out <= b;
                    done     <= 1'b1;
                    state    <= IDLE;
                end else begin
                    res   <= ram[ram_addr];
                    state <= WB;
                end
                WB: begin
                    data_out <= res;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**REG_ADDR_W; i++) regs[i] <= '0;
        end else if (state == WB) begin
            regs[rd] <= res;
        end
    end

    // RAM keeps its contents across reset; the write only fires in MEM
    always_ff @(posedge clk) begin
        if (state == MEM && op == OP_SW) ram[ram_addr] <= b;
    end
endmodule
